// File: rtl/true_dpbram_clr_if.sv
// Port bundle for true_dpbram_clr: clear/busy handshake plus both RAM access ports.
// master: the client that drives addresses, enables, byte writes and data.
// slave:  the RAM, which returns read data, valid strobes and busy.
// Carries collision_o only when TDPBRAM_COLLISION_FLAG_EN is defined.
interface true_dpbram_clr_if #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 8
);
    localparam int unsigned NBYTES = DWIDTH / 8;

    logic              clear_i;
    logic              busy_o;
    logic [AWIDTH-1:0] addr0_i;
    logic              ce0_i;
    logic [NBYTES-1:0] we0_i;
    logic [DWIDTH-1:0] d0_i;
    logic [DWIDTH-1:0] q0_o;
    logic              vld0_o;
    logic [AWIDTH-1:0] addr1_i;
    logic              ce1_i;
    logic [NBYTES-1:0] we1_i;
    logic [DWIDTH-1:0] d1_i;
    logic [DWIDTH-1:0] q1_o;
    logic              vld1_o;

`ifdef TDPBRAM_COLLISION_FLAG_EN
    logic              collision_o;

    modport master (
        output clear_i, addr0_i, ce0_i, we0_i, d0_i, addr1_i, ce1_i, we1_i, d1_i,
        input  busy_o, q0_o, vld0_o, q1_o, vld1_o, collision_o
    );
    modport slave (
        input  clear_i, addr0_i, ce0_i, we0_i, d0_i, addr1_i, ce1_i, we1_i, d1_i,
        output busy_o, q0_o, vld0_o, q1_o, vld1_o, collision_o
    );
`else
    modport master (
        output clear_i, addr0_i, ce0_i, we0_i, d0_i, addr1_i, ce1_i, we1_i, d1_i,
        input  busy_o, q0_o, vld0_o, q1_o, vld1_o
    );
    modport slave (
        input  clear_i, addr0_i, ce0_i, we0_i, d0_i, addr1_i, ce1_i, we1_i, d1_i,
        output busy_o, q0_o, vld0_o, q1_o, vld1_o
    );
`endif
endinterface

// File: rtl/true_dpbram_clr.sv
// True dual-port RAM with byte-lane writes, 1- or 2-cycle read latency and a
// clear sequencer that sweeps INIT_VAL into every word after reset or clear_i.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; restarts the clear sweep
//   bus    true_dpbram_clr_if.slave: clear_i/busy_o, port 0 and port 1
//          (addrN_i, ceN_i, weN_i, dN_i, qN_o, vldN_o)
// Optional: define TDPBRAM_COLLISION_FLAG_EN to add bus.collision_o, a one-cycle
// pulse after both ports hit the same in-range word with at least one write.
module true_dpbram_clr #(
    parameter int unsigned       DWIDTH     = 32,
    parameter int unsigned       AWIDTH     = 8,
    parameter int unsigned       MEM_SIZE   = 256,
    parameter int unsigned       RD_LATENCY = 1,
    parameter int unsigned       WR_MODE    = 0,
    parameter logic [DWIDTH-1:0] INIT_VAL   = '0
) (
    input logic              clk,
    input logic              reset,
    true_dpbram_clr_if.slave bus
);
    localparam int unsigned       NBYTES    = DWIDTH / 8;
    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(MEM_SIZE - 1);

    typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;

    logic [DWIDTH-1:0] mem [MEM_SIZE];

    logic              acc0_c, acc1_c, inr0_c, inr1_c, wr0_c, wr1_c, same_addr_c;
    logic [DWIDTH-1:0] rd0_c, rd1_c;
    logic [DWIDTH-1:0] s1_q0, s1_q1;
    logic              s1_v0, s1_v1;

    // Overlay the enabled byte lanes of new_w onto old_w.
    function automatic logic [DWIDTH-1:0] merge_lanes(input logic [DWIDTH-1:0] old_w,
                                                      input logic [DWIDTH-1:0] new_w,
                                                      input logic [NBYTES-1:0] we);
        logic [DWIDTH-1:0] r;
        r = old_w;
        for (int unsigned k = 0; k < NBYTES; k++) begin
            if (we[k]) r[8*k +: 8] = new_w[8*k +: 8];
        end
        return r;
    endfunction

    // Sweep sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Sweep sequencer next state: one word per cycle, clear_i honoured only when idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                if (bus.clear_i) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + AWIDTH'(1);
                end
            end
            default: begin
                state_d = S_CLEAR;
                cnt_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    // Access acceptance and read-data selection; out-of-range words read as zero.
    always_comb begin
        acc0_c      = bus.ce0_i && (state_q == S_IDLE) && !reset;
        acc1_c      = bus.ce1_i && (state_q == S_IDLE) && !reset;
        inr0_c      = 32'(bus.addr0_i) < MEM_SIZE;
        inr1_c      = 32'(bus.addr1_i) < MEM_SIZE;
        wr0_c       = acc0_c && inr0_c && (|bus.we0_i);
        wr1_c       = acc1_c && inr1_c && (|bus.we1_i);
        same_addr_c = (bus.addr0_i == bus.addr1_i);
        rd0_c       = '0;
        rd1_c       = '0;
        // Write-first merges only the port's own data; the other port always sees the old word.
        if (inr0_c) rd0_c = (WR_MODE == 1) ? merge_lanes(mem[bus.addr0_i], bus.d0_i, bus.we0_i)
                                           : mem[bus.addr0_i];
        if (inr1_c) rd1_c = (WR_MODE == 1) ? merge_lanes(mem[bus.addr1_i], bus.d1_i, bus.we1_i)
                                           : mem[bus.addr1_i];
    end

    // Storage: sweep writes while clearing, otherwise per-lane writes with port 0 winning shared lanes.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem[cnt_q] <= INIT_VAL;
        end else begin
            for (int unsigned k = 0; k < NBYTES; k++) begin
                if (wr0_c && bus.we0_i[k])
                    mem[bus.addr0_i][8*k +: 8] <= bus.d0_i[8*k +: 8];
                if (wr1_c && bus.we1_i[k] && !(wr0_c && same_addr_c && bus.we0_i[k]))
                    mem[bus.addr1_i][8*k +: 8] <= bus.d1_i[8*k +: 8];
            end
        end
    end

    // First read stage; q holds between accepted accesses.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q0 <= '0;
            s1_q1 <= '0;
            s1_v0 <= 1'b0;
            s1_v1 <= 1'b0;
        end else begin
            s1_v0 <= acc0_c;
            s1_v1 <= acc1_c;
            if (acc0_c) s1_q0 <= rd0_c;
            if (acc1_c) s1_q1 <= rd1_c;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [DWIDTH-1:0] s2_q0, s2_q1;
            logic              s2_v0, s2_v1;

            // Optional output register stage.
            always_ff @(posedge clk) begin
                if (reset) begin
                    s2_q0 <= '0;
                    s2_q1 <= '0;
                    s2_v0 <= 1'b0;
                    s2_v1 <= 1'b0;
                end else begin
                    s2_v0 <= s1_v0;
                    s2_v1 <= s1_v1;
                    if (s1_v0) s2_q0 <= s1_q0;
                    if (s1_v1) s2_q1 <= s1_q1;
                end
            end

            assign bus.q0_o   = s2_q0;
            assign bus.q1_o   = s2_q1;
            assign bus.vld0_o = s2_v0;
            assign bus.vld1_o = s2_v1;
        end else begin : g_lat1
            assign bus.q0_o   = s1_q0;
            assign bus.q1_o   = s1_q1;
            assign bus.vld0_o = s1_v0;
            assign bus.vld1_o = s1_v1;
        end
    endgenerate

    assign bus.busy_o = busy_q;

`ifdef TDPBRAM_COLLISION_FLAG_EN
    logic coll_q;

    // Same in-range word on both ports with at least one write.
    always_ff @(posedge clk) begin
        if (reset) coll_q <= 1'b0;
        else       coll_q <= acc0_c && acc1_c && inr0_c && same_addr_c &&
                             ((|bus.we0_i) || (|bus.we1_i));
    end

    assign bus.collision_o = coll_q;
`endif
endmodule
